// File: rtl/pc_fetch_ctrl.sv
// Multi-cycle fetch/PC sequencer: fetches over imem req/ack, holds the instruction for the
// datapath, resolves the next PC after exec_done, counts retirements and traps on bad redirects.
module pc_fetch_ctrl #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc_out,
    input  logic            exec_done,
    input  logic            Branch,
    input  logic            Zero,
    input  logic            Jump,
    input  logic [XLEN-1:0] target,
    output logic            pc_sel,
    output logic            trap,
    output logic [31:0]     retired
);

    // state   | meaning
    // S_READY | idle between instructions, waits for stall=0
    // S_FETCH | imem_req high, waits for imem_ack
    // S_EXEC  | instruction held, waits for exec_done
    // S_TRAP  | misaligned redirect seen, left only by reset
    typedef enum logic [1:0] {
        S_READY = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_TRAP  = 2'd3
    } state_t;

    state_t          state_q, state_n;
    logic [XLEN-1:0] pc_q, pc_out_q, pc_next;
    logic [31:0]     instr_q, retired_q;
    logic            instr_valid_q, pc_sel_q, trap_q;
    logic            do_fetch, do_retire, do_trap, taken;

    always_comb begin
        state_n   = state_q;
        do_fetch  = 1'b0;
        do_retire = 1'b0;
        do_trap   = 1'b0;
        taken     = (Branch & Zero) | Jump;
        pc_next   = taken ? target : pc_q + XLEN'(PC_STEP);
        case (state_q)
            S_READY: begin
                if (!stall) state_n = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    do_fetch = 1'b1;
                    state_n  = S_EXEC;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    if (taken && (target[1:0] != 2'b00)) begin
                        do_trap = 1'b1;
                        state_n = S_TRAP;
                    end else begin
                        do_retire = 1'b1;
                        state_n   = S_READY;
                    end
                end
            end
            S_TRAP:  state_n = S_TRAP;
            default: state_n = S_READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_READY;
            pc_q          <= RESET_PC;
            pc_out_q      <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            pc_sel_q      <= 1'b0;
            trap_q        <= 1'b0;
            retired_q     <= '0;
        end else begin
            state_q       <= state_n;
            instr_valid_q <= 1'b0;
            pc_sel_q      <= 1'b0;
            if (do_fetch) begin
                instr_q       <= imem_rdata;
                pc_out_q      <= pc_q;
                instr_valid_q <= 1'b1;
            end
            if (do_retire) begin
                pc_q      <= pc_next;
                pc_sel_q  <= taken;
                retired_q <= retired_q + 32'd1;
            end
            if (do_trap) trap_q <= 1'b1;
        end
    end

    // Fetch request and address come straight from state so memory sees them with no added latency.
    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc_out      = pc_out_q;
    assign pc_sel      = pc_sel_q;
    assign trap        = trap_q;
    assign retired     = retired_q;

endmodule
